// File: rtl/frame_rx_buffer_pkg.sv
// rtl/frame_rx_buffer_pkg.sv - writer state encodings and word packing for frame_rx_buffer
package frame_rx_buffer_pkg;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_FILL    = 2'd1,
        W_DISCARD = 2'd2
    } wr_state_e;

    localparam int LAST_BIT = 8;
    localparam int WORD_W   = 9;

    function automatic logic [WORD_W-1:0] pack_word(input logic last, input logic [7:0] data);
        logic [WORD_W-1:0] w;
        w           = {1'b0, data};
        w[LAST_BIT] = last;
        return w;
    endfunction

endpackage

// File: rtl/frame_rx_ram.sv
// rtl/frame_rx_ram.sv - simple dual-port frame store, one write port and one registered read port
module frame_rx_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Array contents survive reset; only the visible read register clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/frame_rx_buffer.sv
// rtl/frame_rx_buffer.sv - circular 9-bit frame store with atomic commit; FRAME_RX_BUFFER_DROP_CNT_EN adds drop_count
module frame_rx_buffer
    import frame_rx_buffer_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_byte,
    input  logic              in_byte_valid,
    input  logic              in_byte_last,
    input  logic [ADDR_W-1:0] frame_addr,
    input  logic              frame_latch_tail,
    output logic [8:0]        frame_data,
    output logic              frame_data_valid,
    output logic              frame_valid,
    output logic [ADDR_W-1:0] frame_tail,
    output logic              overflow
`ifdef FRAME_RX_BUFFER_DROP_CNT_EN
    ,
    output logic [7:0]        drop_count
`endif
);

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE = 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] commit_head_q, commit_head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]  frame_count_q, frame_count_d;
    logic              overflow_q, overflow_d;
    logic              frame_data_valid_q, frame_data_valid_d;
    logic              frame_valid_q, frame_valid_d;

    logic              wr_en;
    logic              commit;
    logic              drop;
    logic              full;
    logic              latch_ok;
    logic [ADDR_W-1:0] rel_addr;
    logic [ADDR_W-1:0] rel_commit;

    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        commit_head_d = commit_head_q;
        tail_d        = tail_q;
        frame_count_d = frame_count_q;
        overflow_d    = overflow_q;
        wr_en         = 1'b0;
        commit        = 1'b0;
        drop          = 1'b0;
        full          = (head_q + PTR_ONE) == tail_q;
        latch_ok      = frame_latch_tail && (frame_count_q != '0);

        if (in_byte_valid) begin
            case (state_q)
                W_IDLE, W_FILL: begin
                    if (full) begin
                        // Rewind to the last commit so the partial frame vanishes whole.
                        head_d     = commit_head_q;
                        overflow_d = 1'b1;
                        drop       = 1'b1;
                        state_d    = in_byte_last ? W_IDLE : W_DISCARD;
                    end else begin
                        wr_en  = 1'b1;
                        head_d = head_q + PTR_ONE;
                        if (in_byte_last) begin
                            commit        = 1'b1;
                            commit_head_d = head_q + PTR_ONE;
                            state_d       = W_IDLE;
                        end else begin
                            state_d = W_FILL;
                        end
                    end
                end
                W_DISCARD: begin
                    if (in_byte_last) begin
                        state_d = W_IDLE;
                    end
                end
                default: state_d = W_IDLE;
            endcase
        end

        if (latch_ok) begin
            tail_d = frame_addr;
        end

        if (commit && !latch_ok) begin
            if (frame_count_q != CNT_MAX) begin
                frame_count_d = frame_count_q + CNT_ONE;
            end
        end else if (latch_ok && !commit) begin
            frame_count_d = frame_count_q - CNT_ONE;
        end

        // Offsets from the tail make the committed window a single unsigned compare.
        rel_addr           = frame_addr - tail_q;
        rel_commit         = commit_head_q - tail_q;
        frame_data_valid_d = rel_addr < rel_commit;
        frame_valid_d      = frame_count_d != '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= W_IDLE;
            head_q             <= '0;
            commit_head_q      <= '0;
            tail_q             <= '0;
            frame_count_q      <= '0;
            overflow_q         <= 1'b0;
            frame_data_valid_q <= 1'b0;
            frame_valid_q      <= 1'b0;
        end else begin
            state_q            <= state_d;
            head_q             <= head_d;
            commit_head_q      <= commit_head_d;
            tail_q             <= tail_d;
            frame_count_q      <= frame_count_d;
            overflow_q         <= overflow_d;
            frame_data_valid_q <= frame_data_valid_d;
            frame_valid_q      <= frame_valid_d;
        end
    end

`ifdef FRAME_RX_BUFFER_DROP_CNT_EN
    logic [7:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count_q <= 8'h00;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

    frame_rx_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (WORD_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (head_q),
        .wdata (pack_word(in_byte_last, in_byte)),
        .raddr (frame_addr),
        .rdata (frame_data)
    );

    assign frame_data_valid = frame_data_valid_q;
    assign frame_valid      = frame_valid_q;
    assign frame_tail       = tail_q;
    assign overflow         = overflow_q;

endmodule
